control_unit: RTL
=================

Name: control_unit

Overview:
Multi-cycle FSM sequencer that drives the 8-bit accumulator datapath. Consumes the opcode (IR_CU), compare flag (StopProgram) and ALU carry (cout) produced by the datapath. Generates every datapath load/select strobe, one instruction at a time. Provides a Go/Busy start handshake, halt detection, an instruction counter and a watchdog timeout.

Parameters:
ROM_LAT, 1, cycles spent in S_WAIT for synchronous ROM read (1..7)
MAX_STEPS, 200, instructions retired before forced Timeout halt (1..255)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low; clears all state
Go  in  1  start request, sampled in S_IDLE
IR_CU  in  4  opcode from instruction register
StopProgram  in  1  datapath compare flag (result < A+5B)
cout  in  1  ALU carry out
A_select  out  1  1 = external A into reg A, 0 = ALU result
Aload, Bload, IRload, PCload, ANSload  out  1 each  datapath load strobes
Jump_Sel  out  1  1 = PC takes IR target, 0 = PC+1
SelectMode  out  2  ALU mode, registered, holds between ALU ops
Busy  out  1  high from S_IDLE exit until return to S_IDLE/S_HALT
Halted  out  1  high in S_HALT
Timeout  out  1  sticky, set when MAX_STEPS reached
CarryFlag  out  1  cout captured at last ALU writeback
InstrCount  out  8  instructions retired, saturates at 255

Behaviour:
- Reset (async, Reset=0): state S_IDLE. All strobes, SelectMode, Busy, Halted, Timeout, CarryFlag = 0. InstrCount = 0. Latched opcode op_q = 0.
- Outputs are Moore: decoded from state, op_q and the SelectMode register only. No combinational path from IR_CU to strobes.
- States and transitions:
  - S_IDLE: Go=1 -> S_WAIT, and InstrCount cleared.
  - S_WAIT: hold ROM_LAT cycles (internal counter), then -> S_FETCH. All strobes 0.
  - S_FETCH: IRload=1, PCload=1, Jump_Sel=0 for exactly one cycle -> S_DECODE.
  - S_DECODE: op_q <= IR_CU -> S_EXEC. All strobes 0.
  - S_EXEC: one cycle, per op_q:
    - 0000 NOP: no strobes.
    - 0001 LDA: A_select=1, Aload=1.
    - 0010 LDB: Bload=1.
    - 0011..0110 ALU: SelectMode <= op_q-3 (00..11), ANSload=1 -> S_WB.
    - 0111 JMP: Jump_Sel=1, PCload=1.
    - 1000 JLT: if StopProgram=1, Jump_Sel=1 and PCload=1; else no strobes.
    - 1111 HLT: -> S_HALT.
    - 1001..1110: treated as NOP.
    - All non-ALU, non-HLT ops -> S_RETIRE.
  - S_WB: A_select=0, Aload=1, SelectMode held; CarryFlag <= cout -> S_RETIRE.
  - S_RETIRE: InstrCount += 1 (saturating). If count after increment = MAX_STEPS, Timeout <= 1 -> S_HALT; else -> S_WAIT.
  - S_HALT: Halted=1, Busy=0, all strobes 0. Leaves only when Go=1 -> S_WAIT, clearing Timeout and InstrCount. PC is not reset by this block.
- Busy=1 in S_WAIT, S_FETCH, S_DECODE, S_EXEC, S_WB, S_RETIRE.
- Latency: non-ALU instruction = ROM_LAT+4 cycles; ALU instruction = ROM_LAT+5 cycles.
- JLT samples StopProgram during S_EXEC. SelectMode is still at the previous ALU mode, so the compare reflects the last computed result.
- Go held high in S_IDLE/S_HALT starts exactly once per entry. Go is ignored while Busy.
- HLT does not increment InstrCount. Timeout takes priority over fetching the next instruction.
- Reset asserted mid-instruction: immediate return to S_IDLE, strobes drop in the same cycle, no partial load completes afterwards.
- At most one of {IRload, Aload, Bload, ANSload} is high in any cycle, except Aload with A_select=0 in S_WB. PCload only in S_FETCH or S_EXEC.

Test Plan:
- Reset low mid-S_EXEC of LDA -> Aload falls same cycle. Outputs all 0, state S_IDLE, InstrCount=0.
- Go pulse, program LDA,LDB,0011,HLT (ROM_LAT=1) -> IRload pulses at cycles 2,7,12,18 after Go. Aload in LDA EXEC with A_select=1. ANSload then Aload with A_select=0 on consecutive cycles, SelectMode=00. Halted=1, InstrCount=3.
- JLT with StopProgram=1 -> Jump_Sel=1 and PCload=1 for one EXEC cycle. Repeat with StopProgram=0 -> no PCload in EXEC.
- MAX_STEPS=4, program JMP 0 (infinite loop) -> after 4th retire Timeout=1, Halted=1, InstrCount=4, no further IRload.
- ALU op 0110 with cout=1 during S_WB -> SelectMode=11 persists into the next instruction. CarryFlag=1 until the next ALU writeback.
- Undefined opcode 1010 -> no strobes in EXEC, InstrCount increments by 1. Go asserted while Busy -> no effect.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer for the 8-bit accumulator datapath.
// Walks one instruction at a time through WAIT/FETCH/DECODE/EXEC(/WB)/RETIRE.
// It also handles the Go/Busy start handshake, halt detection, a saturating
// instruction counter and a watchdog that forces a halt after MAX_STEPS
// retired instructions.
module control_unit #(
  parameter int unsigned ROM_LAT   = 1,   // S_WAIT cycles for the ROM read (1..7)
  parameter int unsigned MAX_STEPS = 200  // retire count that forces Timeout (1..255)
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Go,
  input  logic [3:0] IR_CU,
  input  logic       StopProgram,
  input  logic       cout,
  output logic       A_select,
  output logic       Aload,
  output logic       Bload,
  output logic       IRload,
  output logic       PCload,
  output logic       ANSload,
  output logic       Jump_Sel,
  output logic [1:0] SelectMode,
  output logic       Busy,
  output logic       Halted,
  output logic       Timeout,
  output logic       CarryFlag,
  output logic [7:0] InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_RETIRE,
    S_HALT
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(ROM_LAT - 1);
  localparam logic [7:0] MAX_CNT   = 8'(MAX_STEPS);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JLT = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] sel_q, sel_d;
  logic       timeout_q, timeout_d;
  logic       carry_q, carry_d;
  logic [7:0] count_q, count_d;

  logic       is_alu;
  logic [3:0] op_minus3;
  logic [7:0] count_inc;
  logic       start;

  // ALU opcodes are 3..6; their mode is simply the offset from 3.
  assign is_alu    = (op_q >= 4'd3) && (op_q <= 4'd6);
  assign op_minus3 = op_q - 4'd3;
  assign count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
  assign start     = Go && ((state_q == S_IDLE) || (state_q == S_HALT));

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a watchdog halt wins over fetching the next instruction
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (Go) state_d = S_WAIT;
      S_WAIT:   if (wait_cnt_q == WAIT_LAST) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (op_q == OP_HLT)  state_d = S_HALT;
        else if (is_alu)     state_d = S_WB;
        else                 state_d = S_RETIRE;
      end
      S_WB:     state_d = S_RETIRE;
      S_RETIRE: state_d = (count_inc == MAX_CNT) ? S_HALT : S_WAIT;
      S_HALT:   if (Go) state_d = S_WAIT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the bookkeeping registers (opcode latch, ROM wait, mode, flags, count)
  always_comb begin
    op_d       = (state_q == S_DECODE) ? IR_CU : op_q;
    wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + 3'd1 : 3'd0;
    sel_d      = ((state_q == S_EXEC) && is_alu) ? op_minus3[1:0] : sel_q;
    carry_d    = (state_q == S_WB) ? cout : carry_q;

    count_d = count_q;
    if (start)                    count_d = 8'd0;
    else if (state_q == S_RETIRE) count_d = count_inc;

    timeout_d = timeout_q;
    if (start)                                           timeout_d = 1'b0;
    else if ((state_q == S_RETIRE) && (count_inc == MAX_CNT)) timeout_d = 1'b1;
  end

  // Bookkeeping registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      op_q       <= 4'd0;
      wait_cnt_q <= 3'd0;
      sel_q      <= 2'd0;
      carry_q    <= 1'b0;
      count_q    <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
      sel_q      <= sel_d;
      carry_q    <= carry_d;
      count_q    <= count_d;
      timeout_q  <= timeout_d;
    end
  end

  // Strobe decode from state and latched opcode; only JLT also looks at the compare flag
  always_comb begin
    A_select = 1'b0;
    Aload    = 1'b0;
    Bload    = 1'b0;
    IRload   = 1'b0;
    PCload   = 1'b0;
    ANSload  = 1'b0;
    Jump_Sel = 1'b0;
    Busy     = 1'b0;
    Halted   = 1'b0;
    case (state_q)
      S_WAIT, S_DECODE, S_RETIRE: Busy = 1'b1;
      S_FETCH: begin
        Busy   = 1'b1;
        IRload = 1'b1;
        PCload = 1'b1;
      end
      S_EXEC: begin
        Busy = 1'b1;
        case (op_q)
          OP_LDA: begin
            A_select = 1'b1;
            Aload    = 1'b1;
          end
          OP_LDB: Bload = 1'b1;
          4'h3, 4'h4, 4'h5, 4'h6: ANSload = 1'b1;
          OP_JMP: begin
            Jump_Sel = 1'b1;
            PCload   = 1'b1;
          end
          OP_JLT: begin
            Jump_Sel = StopProgram;
            PCload   = StopProgram;
          end
          default: ;
        endcase
      end
      S_WB: begin
        Busy  = 1'b1;
        Aload = 1'b1;
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

  assign SelectMode = sel_q;
  assign Timeout    = timeout_q;
  assign CarryFlag  = carry_q;
  assign InstrCount = count_q;

endmodule
